// File: rtl/mem_config_pkg.sv
// Memory geometry shared by the scan controller and the memories around it.
package mem_config_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/sobel_config_pkg.sv
// Image geometry defaults, controller state encoding and window slot helpers.
package sobel_config_pkg;

    localparam int IMG_W      = 64;
    localparam int IMG_H      = 48;
    localparam int WIN_SLOTS  = 9;
    localparam int FETCH_LAST = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_WRITE,
        ST_DONE
    } sobel_state_e;

    function automatic logic [1:0] slot_row(input logic [3:0] k);
        return 2'(k / 4'd3);
    endfunction

    function automatic logic [1:0] slot_col(input logic [3:0] k);
        return 2'(k % 4'd3);
    endfunction

endpackage

// File: rtl/sobel_scan_ctrl_if.sv
// Bus bundle between the scan controller, its two memories and the Sobel core.
interface sobel_scan_ctrl_if;
    import mem_config_pkg::*;

    logic [ADDR_WIDTH-1:0]   in_addr_o;
    logic                    in_wr_en_o;
    logic [DATA_WIDTH-1:0]   in_data_i;

    // A window moves only on a cycle where win_valid_o && win_ready_i; while
    // valid is high without ready, win_o is held stable and valid stays high.
    logic                    win_valid_o;
    logic                    win_ready_i;
    logic [9*DATA_WIDTH-1:0] win_o;

    logic                    res_valid_i;
    logic [DATA_WIDTH-1:0]   res_data_i;

    logic [ADDR_WIDTH-1:0]   out_addr_o;
    logic                    out_wr_en_o;
    logic [DATA_WIDTH-1:0]   out_data_o;

    modport master (
        output in_addr_o, in_wr_en_o,
        input  in_data_i,
        output win_valid_o, win_o,
        input  win_ready_i,
        input  res_valid_i, res_data_i,
        output out_addr_o, out_wr_en_o, out_data_o
    );

    modport slave (
        input  in_addr_o, in_wr_en_o,
        output in_data_i,
        input  win_valid_o, win_o,
        output win_ready_i,
        output res_valid_i, res_data_i,
        input  out_addr_o, out_wr_en_o, out_data_o
    );

endinterface

// File: rtl/sobel_window_buf.sv
// Nine-slot capture register for one 3x3 neighbourhood, exposed as a flat vector.
module sobel_window_buf
    import sobel_config_pkg::*;
#(
    parameter int DATA_WIDTH = mem_config_pkg::DATA_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [3:0]                     wr_idx_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    output logic [WIN_SLOTS*DATA_WIDTH-1:0] win_o
);

    logic [DATA_WIDTH-1:0] slot_q [WIN_SLOTS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < WIN_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (wr_en_i && (wr_idx_i < 4'(WIN_SLOTS))) begin
            slot_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        win_o = '0;
        for (int k = 0; k < WIN_SLOTS; k++) begin
            win_o[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
        end
    end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Sobel frame scanner: walks the image in raster order, gathers each interior
// 3x3 neighbourhood, hands it to the core and writes one result per pixel.
module sobel_scan_ctrl
    import sobel_config_pkg::*;
    import mem_config_pkg::*;
#(
    parameter int IMG_W = sobel_config_pkg::IMG_W,
    parameter int IMG_H = sobel_config_pkg::IMG_H
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output sobel_state_e      dbg_state_o,
    sobel_scan_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] W_A    = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(IMG_H - 1);

    if ((IMG_W < 3) || (IMG_H < 3) ||
        (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_WIDTH))) begin : g_bad_cfg
        $error("sobel_scan_ctrl: image geometry does not fit ADDR_WIDTH or is below 3x3");
    end

    sobel_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [3:0]            k_q, k_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;

    logic                  is_border;
    logic [ADDR_WIDTH-1:0] fetch_row, fetch_col, fetch_addr, pix_addr;
    logic                  cap_en;
    logic [3:0]            cap_idx;

    assign is_border = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);

    // Neighbourhood offsets only apply to interior pixels, so the -1 never wraps when used.
    assign fetch_row  = y_q + ADDR_WIDTH'(slot_row(k_q)) - ADDR_WIDTH'(1);
    assign fetch_col  = x_q + ADDR_WIDTH'(slot_col(k_q)) - ADDR_WIDTH'(1);
    assign fetch_addr = fetch_row * W_A + fetch_col;
    assign pix_addr   = y_q * W_A + x_q;

    // Read data lags the address by one cycle, so slot k lands on FETCH cycle k+1.
    assign cap_en  = (state_q == ST_FETCH) && (k_q != 4'd0);
    assign cap_idx = k_q - 4'd1;

    sobel_window_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_window_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (cap_en),
        .wr_idx_i  (cap_idx),
        .wr_data_i (bus.in_data_i),
        .win_o     (bus.win_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        k_d             = k_q;
        res_d           = res_q;
        bus.in_addr_o   = '0;
        bus.win_valid_o = 1'b0;
        bus.out_addr_o  = '0;
        bus.out_wr_en_o = 1'b0;
        bus.out_data_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                k_d = '0;
                if (is_border) begin
                    res_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (k_q < 4'(FETCH_LAST)) begin
                    bus.in_addr_o = fetch_addr;
                end
                if (k_q == 4'(FETCH_LAST)) begin
                    state_d = ST_ISSUE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_ISSUE: begin
                bus.win_valid_o = 1'b1;
                if (bus.win_ready_i) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (bus.res_valid_i) begin
                    res_d   = bus.res_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.out_wr_en_o = 1'b1;
                bus.out_addr_o  = pix_addr;
                bus.out_data_o  = res_q;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        y_d     = y_q + ADDR_WIDTH'(1);
                        state_d = ST_SELECT;
                    end
                end else begin
                    x_d     = x_q + ADDR_WIDTH'(1);
                    state_d = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_wr_en_o = 1'b0;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Directed bench for sobel_scan_ctrl on a 4x4 frame whose pixel value equals its address.
`timescale 1ns/1ps
module tb_sobel_scan_ctrl;
    import sobel_config_pkg::*;
    import mem_config_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = ADDR_WIDTH + DATA_WIDTH;
    localparam int WW = 9 * DATA_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done;
    sobel_state_e dbg_state;

    always #5 clk = ~clk;

    sobel_scan_ctrl_if bus ();

    sobel_scan_ctrl #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    // ---------------- memory and core models ----------------
    logic [DATA_WIDTH-1:0] mem_rd_q;
    logic                  win_ready;
    logic                  auto_en;
    logic                  auto_res_q;
    logic                  man_res;
    logic [DATA_WIDTH-1:0] res_value;

    assign bus.in_data_i   = mem_rd_q;
    assign bus.win_ready_i = win_ready;
    assign bus.res_valid_i = auto_res_q | man_res;
    assign bus.res_data_i  = res_value;

    always @(posedge clk) begin
        mem_rd_q   <= (bus.in_addr_o < ADDR_WIDTH'(W * H)) ? DATA_WIDTH'(bus.in_addr_o)
                                                           : DATA_WIDTH'('hEE);
        auto_res_q <= auto_en && bus.win_valid_o && bus.win_ready_i;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [PW-1:0]         exp_q[$];
    logic [PW-1:0]         got_wr_q[$];
    logic [ADDR_WIDTH-1:0] rd_q[$];
    logic [WW-1:0]         win_q[$];

    int exp11[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int exp22[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    always @(negedge clk) begin
        if (bus.out_wr_en_o) got_wr_q.push_back({bus.out_addr_o, bus.out_data_o});
        if (bus.win_valid_o && bus.win_ready_i) win_q.push_back(bus.win_o);
        if (dbg_state == ST_FETCH) rd_q.push_back(bus.in_addr_o);
        if (done) done_cnt++;
    end

    function automatic logic [WW-1:0] win_of(input bit second);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(second ? exp22[k] : exp11[k]);
        end
        return w;
    endfunction

    function automatic void build_exp(input logic [DATA_WIDTH-1:0] interior);
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == 0 || x == W - 1 || y == 0 || y == H - 1)
                    exp_q.push_back({ADDR_WIDTH'(y * W + x), DATA_WIDTH'(0)});
                else
                    exp_q.push_back({ADDR_WIDTH'(y * W + x), interior});
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_sb();
        got_wr_q.delete();
        rd_q.delete();
        win_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_state(input sobel_state_e target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dbg_state == target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        checks++;
        if (bus.in_addr_o !== '0 || bus.in_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL reset_in_port: addr %h we %b want 0/0", bus.in_addr_o, bus.in_wr_en_o);
        end
        checks++;
        if (bus.win_valid_o !== 1'b0 || bus.win_o !== '0) begin
            errors++; $display("FAIL reset_window: valid %b win %h want 0/0", bus.win_valid_o, bus.win_o);
        end
        checks++;
        if (bus.out_wr_en_o !== 1'b0 || bus.out_addr_o !== '0 || bus.out_data_o !== '0) begin
            errors++; $display("FAIL reset_out_port: we %b addr %h data %h want 0", bus.out_wr_en_o, bus.out_addr_o, bus.out_data_o);
        end
    endtask

    task automatic test_window_reads();
        bit ok;
        clear_sb();
        auto_en = 1'b1; win_ready = 1'b1; res_value = 8'hAA;
        pulse_start();
        wait_state(ST_DONE, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reads_done_timeout: state %0d want DONE", dbg_state); end
        step(); step();
        checks++;
        if (rd_q.size() !== 40) begin errors++; $display("FAIL reads_count: got %0d want 40", rd_q.size()); end
        if (rd_q.size() >= 40) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (rd_q[k] !== ADDR_WIDTH'(exp11[k])) begin
                    errors++; $display("FAIL reads_p11_k%0d: got %0d want %0d", k, rd_q[k], exp11[k]);
                end
                checks++;
                if (rd_q[30 + k] !== ADDR_WIDTH'(exp22[k])) begin
                    errors++; $display("FAIL reads_p22_k%0d: got %0d want %0d", k, rd_q[30 + k], exp22[k]);
                end
            end
        end
        checks++;
        if (win_q.size() !== 4) begin errors++; $display("FAIL win_count: got %0d want 4", win_q.size()); end
        if (win_q.size() >= 4) begin
            checks++;
            if (win_q[0] !== win_of(1'b0)) begin errors++; $display("FAIL win_p11: got %h want %h", win_q[0], win_of(1'b0)); end
            checks++;
            if (win_q[3] !== win_of(1'b1)) begin errors++; $display("FAIL win_p22: got %h want %h", win_q[3], win_of(1'b1)); end
        end
    endtask

    task automatic test_frame_writes();
        bit ok;
        clear_sb();
        auto_en = 1'b1; win_ready = 1'b1; res_value = 8'hAA;
        build_exp(8'hAA);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b want 1", busy); end
        wait_state(ST_DONE, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_done_timeout: state %0d want DONE", dbg_state); end
        step(); step();
        checks++;
        if (got_wr_q.size() !== 16) begin errors++; $display("FAIL frame_write_count: got %0d want 16", got_wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_wr_q.size(); i++) begin
            checks++;
            if (got_wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL frame_write_%0d: got %h want %h", i, got_wr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_ready_stall();
        bit ok;
        clear_sb();
        auto_en = 1'b1; win_ready = 1'b0; res_value = 8'hAA;
        pulse_start();
        wait_state(ST_ISSUE, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_issue_timeout: state %0d want ISSUE", dbg_state); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.win_valid_o !== 1'b1 || bus.win_o !== win_of(1'b0)) begin
                errors++; $display("FAIL stall_cycle%0d: valid %b win %h want 1 %h", i, bus.win_valid_o, bus.win_o, win_of(1'b0));
            end
            step();
        end
        win_ready = 1'b1;
        step();
        checks++;
        if (dbg_state !== ST_WAIT_RES) begin errors++; $display("FAIL stall_release: state %0d want %0d", dbg_state, ST_WAIT_RES); end
        wait_state(ST_DONE, 400, ok);
        step(); step();
        checks++;
        if (!ok || done_cnt !== 1 || got_wr_q.size() !== 16) begin
            errors++; $display("FAIL stall_frame_end: done %0d writes %0d want 1/16", done_cnt, got_wr_q.size());
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        clear_sb();
        auto_en = 1'b1; win_ready = 1'b1; res_value = 8'h77;
        pulse_start();
        wait_state(ST_FETCH, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstf_fetch_timeout: state %0d want FETCH", dbg_state); end
        step(); step(); step(); step();
        checks++;
        if (bus.in_addr_o !== ADDR_WIDTH'(exp11[4])) begin
            errors++; $display("FAIL rstf_cycle4_addr: got %0d want %0d", bus.in_addr_o, exp11[4]);
        end
        rst = 1'b1;
        step();
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstf_state: state %0d busy %b done %b want IDLE/0/0", dbg_state, busy, done);
        end
        checks++;
        if (bus.in_addr_o !== '0 || bus.win_valid_o !== 1'b0 || bus.win_o !== '0) begin
            errors++; $display("FAIL rstf_fetch_side: addr %h valid %b win %h want 0", bus.in_addr_o, bus.win_valid_o, bus.win_o);
        end
        checks++;
        if (bus.out_wr_en_o !== 1'b0 || bus.out_addr_o !== '0 || bus.out_data_o !== '0) begin
            errors++; $display("FAIL rstf_out_side: we %b addr %h data %h want 0", bus.out_wr_en_o, bus.out_addr_o, bus.out_data_o);
        end
        rst = 1'b0;
        checks++;
        if (got_wr_q.size() !== 5) begin errors++; $display("FAIL rstf_border_writes: got %0d want 5", got_wr_q.size()); end
        man_res = 1'b1;
        step();
        man_res = 1'b0;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (got_wr_q.size() !== 5 || dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL rstf_late_result: writes %0d state %0d want 5/IDLE", got_wr_q.size(), dbg_state);
        end
    endtask

    task automatic test_start_ignored();
        bit seen_done;
        clear_sb();
        auto_en = 1'b1; win_ready = 1'b1; res_value = 8'hAA;
        seen_done = 1'b0;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (dbg_state == ST_DONE) begin
                seen_done = 1'b1;
                break;
            end
            start = (i % 5 == 0);
            step();
        end
        start = 1'b0;
        checks++;
        if (!seen_done) begin errors++; $display("FAIL busy_start_timeout: state %0d want DONE", dbg_state); end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
        checks++;
        if (got_wr_q.size() !== 16) begin errors++; $display("FAIL busy_start_writes: got %0d want 16", got_wr_q.size()); end
        checks++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL busy_start_idle: busy %b state %0d want 0/IDLE", busy, dbg_state);
        end
    endtask

    task automatic test_res_during_fetch();
        bit ok;
        clear_sb();
        auto_en = 1'b0; win_ready = 1'b1; res_value = 8'h55;
        build_exp(8'h33);
        pulse_start();
        wait_state(ST_FETCH, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL early_fetch_timeout: state %0d want FETCH", dbg_state); end
        step(); step();
        man_res = 1'b1;
        step();
        man_res = 1'b0;
        wait_state(ST_WAIT_RES, 50, ok);
        step(); step(); step();
        checks++;
        if (!ok || dbg_state !== ST_WAIT_RES) begin
            errors++; $display("FAIL early_wait_res: state %0d want %0d", dbg_state, ST_WAIT_RES);
        end
        checks++;
        if (got_wr_q.size() !== 5) begin errors++; $display("FAIL early_no_write: got %0d want 5", got_wr_q.size()); end
        res_value = 8'h33;
        man_res = 1'b1;
        step();
        man_res = 1'b0;
        checks++;
        if (bus.out_wr_en_o !== 1'b1 || bus.out_addr_o !== ADDR_WIDTH'(5) || bus.out_data_o !== 8'h33) begin
            errors++; $display("FAIL early_write_p11: we %b addr %0d data %h want 1/5/33", bus.out_wr_en_o, bus.out_addr_o, bus.out_data_o);
        end
        auto_en = 1'b1;
        wait_state(ST_DONE, 400, ok);
        step(); step();
        checks++;
        if (!ok || done_cnt !== 1 || got_wr_q.size() !== 16) begin
            errors++; $display("FAIL early_frame_end: done %0d writes %0d want 1/16", done_cnt, got_wr_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_wr_q.size(); i++) begin
            checks++;
            if (got_wr_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL early_write_%0d: got %h want %h", i, got_wr_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; start = 1'b0; win_ready = 1'b0;
        auto_en = 1'b0; man_res = 1'b0; res_value = '0;
        test_reset();
        test_window_reads();
        test_frame_writes();
        test_ready_stall();
        test_reset_mid_fetch();
        test_start_ignored();
        test_res_during_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, state %0d", dbg_state);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sobel_scan_ctrl.md
SOBEL_SCAN_CTRL -- requirements
Module: sobel_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default IMG_W from sobel_config_pkg: image width in pixels.
REQ-002 Parameter IMG_H, default IMG_H from sobel_config_pkg: image height in pixels.
REQ-003 clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  frame start request, sampled in IDLE only.
REQ-006 busy_o  out  1  high from the cycle after start is accepted until DONE inclusive.
REQ-007 done_o  out  1  one-cycle pulse at end of frame.
REQ-008 in_addr_o  out  ADDR_WIDTH  input-memory read address.
REQ-009 in_wr_en_o  out  1  input-memory write enable, constant 0.
REQ-010 in_data_i  in  DATA_WIDTH  input-memory read data, valid one cycle after in_addr_o.
REQ-011 win_valid_o  out  1  3x3 window valid to Sobel core.
REQ-012 win_ready_i  in  1  Sobel core accepts the window.
REQ-013 win_o  out  9*DATA_WIDTH  window, slot k at bits [k*DATA_WIDTH +: DATA_WIDTH], k = 3*row + col.
REQ-014 res_valid_i  in  1  Sobel result valid.
REQ-015 res_data_i  in  DATA_WIDTH  Sobel result magnitude.
REQ-016 out_addr_o  out  ADDR_WIDTH  output-memory address.
REQ-017 out_wr_en_o  out  1  output-memory write enable.
REQ-018 out_data_o  out  DATA_WIDTH  output-memory write data.

Function
REQ-019 States: IDLE, SELECT, FETCH, ISSUE, WAIT_RES, WRITE, DONE.
REQ-020 IDLE + start_i -> SELECT with x=0, y=0; start_i outside IDLE is ignored.
REQ-021 SELECT (1 cycle): border pixel (x==0, x==IMG_W-1, y==0 or y==IMG_H-1) -> WRITE with data 0; otherwise -> FETCH.
REQ-022 FETCH lasts exactly 10 cycles: cycle k (0..8) drives in_addr_o = (y-1+k/3)*IMG_W + (x-1+k%3); cycle k+1 captures in_data_i into slot k; then -> ISSUE.
REQ-023 ISSUE: win_valid_o=1, win_o held stable until win_valid_o && win_ready_i, then -> WAIT_RES.
REQ-024 WAIT_RES: first res_valid_i captures res_data_i -> WRITE; res_valid_i in any other state is ignored.
REQ-025 WRITE (1 cycle): out_wr_en_o=1, out_addr_o = y*IMG_W + x, out_data_o = result or 0.
REQ-026 After WRITE: x increments; at x==IMG_W-1 x wraps to 0 and y increments; last pixel (IMG_W-1, IMG_H-1) -> DONE, else -> SELECT.
REQ-027 DONE (1 cycle): done_o=1 -> IDLE.
REQ-028 Raster order; exactly IMG_W*IMG_H writes per frame, each address once.
REQ-029 Address arithmetic in ADDR_WIDTH bits, no truncation; elaboration SHALL fail if IMG_W*IMG_H > 2**ADDR_WIDTH, IMG_W<3 or IMG_H<3.
REQ-030 in_addr_o, out_addr_o, out_data_o = 0 outside FETCH/WRITE respectively.

Reset
REQ-031 rst_i high at a clock edge -> IDLE, x=y=0, window slots 0, all outputs 0, from any state including mid-FETCH or ISSUE.
REQ-032 A result arriving after reset is ignored; no output write occurs until the next start.

Structure
REQ-033 State enum typedef and IMG_W/IMG_H defaults in sobel_config_pkg; ADDR_WIDTH/DATA_WIDTH from mem_config_pkg.
REQ-034 One sub-module sobel_window_buf: 9-slot capture register with slot-index write port and flat output.

Verification
REQ-035 4x4 frame 0x00..0x0F, ready/result immediate: pixel (1,1) reads 0,1,2,4,5,6,8,9,10; pixel (2,2) reads 5,6,7,9,10,11,13,14,15.
REQ-036 Same frame, result = 0xAA: out addrs 5,6,9,10 = 0xAA, other 12 = 0; 16 writes, one done_o.
REQ-037 win_ready_i low 5 cycles in ISSUE -> win_valid_o high, win_o unchanged all 5 cycles.
REQ-038 rst_i in FETCH cycle 4 -> next cycle IDLE, all outputs 0; later res_valid_i produces no write.
REQ-039 start_i pulsed while busy_o=1 -> ignored; exactly one done_o per accepted start.
REQ-040 res_valid_i pulsed during FETCH -> ignored; WAIT_RES waits for next pulse.
